stack_access_ctrl: RTL and testbench
====================================

Name: stack_access_ctrl

Overview:
- Sequences every stack memory transaction: PUSH, POP, CALL, RET, INT and RTI.
- Sits between the execute-stage control and the 16-bit data memory.
- Drives the stack pointer register's enable/direction inputs and uses its 32-bit sp output as the memory address.
- Splits multi-word transfers (32-bit PC, 16-bit flags) into ordered single-word accesses through a small FSM.

Parameters:
- ADDR_W, 11, data-memory word-address width.
- STACK_TOP, 2047, highest stack address; equals the stack pointer's reset value.
- STACK_LIMIT, 1024, lowest legal push address (bounds checking only).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- req  in  1  start request; sampled only in IDLE
- op  in  3  0 PUSH, 1 POP, 2 CALL, 3 RET, 4 INT, 5 RTI, 6-7 NOP
- push_data  in  16  PUSH operand
- pc_in  in  32  return PC for CALL/INT
- flags_in  in  16  flags for INT
- sp  in  32  current stack pointer
- sp_en  out  1  stack pointer enable
- sp_pop  out  1  direction: 0 decrement (push), 1 increment (pop)
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  16  write data
- mem_we  out  1  write strobe
- mem_re  out  1  read strobe
- mem_rdata  in  16  read data, valid the cycle after mem_re
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- pop_data  out  16  POP result
- pc_out  out  32  RET/RTI PC
- flags_out  out  16  RTI flags
- err  out  1  bounds violation; qualifies done

Behaviour:
- Interface: reset rst, synchronous, active-high; clock clk.
- Reset: state IDLE; sp_en, sp_pop, mem_we, mem_re, done, err, busy = 0; mem_addr, mem_wdata, pop_data, pc_out, flags_out = 0.
- States: IDLE, WR, RD, CAP, DONE. A 2-bit word counter tracks position within the sequence.
- IDLE: req=1 latches op, push_data, pc_in and flags_in (cycle N). Go to WR (PUSH/CALL/INT), RD (POP/RET/RTI) or DONE (NOP).
- WR cycle, one word per cycle:
  - mem_we=1, mem_addr=sp[ADDR_W-1:0], mem_wdata=current word.
  - sp_en=1, sp_pop=0 in the same cycle, so sp post-decrements at that edge.
  - Word order: PUSH: push_data. CALL: pc[31:16], pc[15:0]. INT: pc[31:16], pc[15:0], flags.
- RD cycle, one word per cycle:
  - mem_re=1, mem_addr=(sp+1)[ADDR_W-1:0].
  - sp_en=1, sp_pop=1 in the same cycle.
  - Each returned word is captured in the following cycle.
  - Pop order: POP: data. RET: pc lo, pc hi. RTI: flags, pc lo, pc hi.
- CAP: captures the final read word. Result registers update at the end of CAP.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency from acceptance cycle N with k words:
  - Writes: done at N+k+1.
  - Reads: done at N+k+2.
  - NOP: done at N+1.
- Results hold until overwritten by a later read op; write ops leave them unchanged.
- req is ignored while busy=1, so a back-to-back req is accepted only once IDLE is re-entered.
- Address arithmetic is 32-bit, then truncated to ADDR_W. Without bounds checking, a pop at sp=2047 wraps to address 0.
- Reset mid-operation: next edge returns to IDLE and all strobes drop. Words already written and sp steps already taken are not undone.
- An op value latched while busy is never altered by changes on the input pins.

Optional Feature:
- Macro: STACK_BOUNDS_EN.
- Defined: before every access the word is checked.
  - Write with sp < STACK_LIMIT is an overflow.
  - Read with sp+1 > STACK_TOP is an underflow.
  - A violating word issues no mem strobe and no sp_en. FSM jumps to DONE with err=1 alongside done.
  - Earlier words of the sequence remain committed; result registers are not updated.
- Undefined: no checks; err tied to 0; addresses wrap.

Test Plan:
1. Reset, then PUSH push_data=0xBEEF with sp=2047 -> cycle N+1: mem_we=1, addr 2047, wdata 0xBEEF, sp_en=1, sp_pop=0; done at N+2; busy high N+1..N+2.
2. CALL pc_in=0x0001_2345, sp=2047 -> writes 0x0001@2047 then 0x2345@2046 on consecutive cycles; sp ends at 2045; done at N+3.
3. RET after test 2 (sp=2045) -> reads addr 2046 then 2047; pc_out=0x0001_2345 valid with done at N+4; sp back to 2047.
4. INT pc=0x0000_00A0, flags=0x0005, then RTI -> flags_out=0x0005 and pc_out=0x0000_00A0; sp returns to the initial value; RTI done at N+5.
5. Assert rst during the second WR cycle of CALL -> next cycle: IDLE, mem_we=0, busy=0, done=0; first word stays in memory.
6. With STACK_BOUNDS_EN, POP at sp=2047 -> no mem_re, no sp_en; done=1 and err=1 at N+1. Without the macro -> mem_re at addr 0, sp_en=1, err stays 0.

Source files
------------

// File: rtl/stack_access_ctrl.sv
// Stack transaction sequencer: splits PUSH/POP/CALL/RET/INT/RTI into single-word
// memory accesses and steers the external stack pointer. Define STACK_BOUNDS_EN for overflow/underflow checks.
module stack_access_ctrl #(
  parameter int ADDR_W      = 11,
  parameter int STACK_TOP   = 2047,
  parameter int STACK_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [15:0]       push_data,
  input  logic [31:0]       pc_in,
  input  logic [15:0]       flags_in,
  input  logic [31:0]       sp,
  output logic              sp_en,
  output logic              sp_pop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [15:0]       mem_rdata,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pop_data,
  output logic [31:0]       pc_out,
  output logic [15:0]       flags_out,
  output logic              err
);

`ifdef STACK_BOUNDS_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_INT  = 3'd4;
  localparam logic [2:0] OP_RTI  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CAP, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [2:0]  op_q;
  logic [15:0] pdata_q, flags_q;
  logic [31:0] pc_q;
  logic [15:0] w0_q, w1_q;
  logic [15:0] pop_data_q, flags_out_q;
  logic [31:0] pc_out_q;
  logic [31:0] sp_plus1;

  assign sp_plus1 = sp + 32'd1;

  function automatic logic is_wr(input logic [2:0] o);
    is_wr = (o == OP_PUSH) || (o == OP_CALL) || (o == OP_INT);
  endfunction

  function automatic logic is_rd(input logic [2:0] o);
    is_rd = (o == OP_POP) || (o == OP_RET) || (o == OP_RTI);
  endfunction

  function automatic logic [1:0] last_idx(input logic [2:0] o);
    case (o)
      OP_CALL, OP_RET: last_idx = 2'd1;
      OP_INT, OP_RTI:  last_idx = 2'd2;
      default:         last_idx = 2'd0;
    endcase
  endfunction

  // Bounds are evaluated on the full 32-bit address before truncation.
  function automatic logic wr_viol(input logic [31:0] a);
    wr_viol = BOUNDS_EN && (a < 32'(STACK_LIMIT));
  endfunction

  function automatic logic rd_viol(input logic [31:0] a);
    rd_viol = BOUNDS_EN && (a > 32'(STACK_TOP));
  endfunction

  function automatic logic [15:0] wr_word(input logic [2:0] o, input logic [1:0] c,
                                          input logic [15:0] pd, input logic [31:0] pc,
                                          input logic [15:0] fl);
    if (o == OP_PUSH) begin
      wr_word = pd;
    end else begin
      case (c)
        2'd0:    wr_word = pc[31:16];
        2'd1:    wr_word = pc[15:0];
        default: wr_word = fl;
      endcase
    end
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    sp_en     = 1'b0;
    sp_pop    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          cnt_d = 2'd0;
          err_d = 1'b0;
          if (is_wr(op)) begin
            if (wr_viol(sp)) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              state_d = S_WR;
            end
          end else if (is_rd(op)) begin
            if (rd_viol(sp_plus1)) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end else begin
              state_d = S_RD;
            end
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WR: begin
        mem_we    = 1'b1;
        mem_addr  = sp[ADDR_W-1:0];
        mem_wdata = wr_word(op_q, cnt_q, pdata_q, pc_q, flags_q);
        sp_en     = 1'b1;
        if (cnt_q == last_idx(op_q)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 2'd1;
          // Next word will see sp already decremented by this access.
          if (wr_viol(sp - 32'd1)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_RD: begin
        mem_re   = 1'b1;
        mem_addr = sp_plus1[ADDR_W-1:0];
        sp_en    = 1'b1;
        sp_pop   = 1'b1;
        if (cnt_q == last_idx(op_q)) begin
          state_d = S_CAP;
        end else begin
          cnt_d = cnt_q + 2'd1;
          if (rd_viol(sp + 32'd2)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end
        end
      end
      S_CAP:   state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 2'd0;
      err_q       <= 1'b0;
      pop_data_q  <= '0;
      pc_out_q    <= '0;
      flags_out_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == S_CAP) begin
        case (op_q)
          OP_POP: pop_data_q <= mem_rdata;
          OP_RET: pc_out_q   <= {mem_rdata, w0_q};
          OP_RTI: begin
            flags_out_q <= w0_q;
            pc_out_q    <= {mem_rdata, w1_q};
          end
          default: ;
        endcase
      end
    end
  end

  // Operand latch and read-word capture; each RD cycle sees the previous word's data.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && req) begin
      op_q    <= op;
      pdata_q <= push_data;
      pc_q    <= pc_in;
      flags_q <= flags_in;
    end
    if (state_q == S_RD) begin
      if (cnt_q == 2'd1) w0_q <= mem_rdata;
      if (cnt_q == 2'd2) w1_q <= mem_rdata;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign err       = done && err_q;
  assign pop_data  = pop_data_q;
  assign pc_out    = pc_out_q;
  assign flags_out = flags_out_q;

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Scoreboard bench for stack_access_ctrl: a stack-pointer and memory model surround the DUT,
// expected accesses and completions are queued at issue time and checked by a monitor.
module tb_stack_access_ctrl;
  localparam int ADDR_W = 11;
  localparam logic [2:0] OP_PUSH = 3'd0, OP_POP = 3'd1, OP_CALL = 3'd2,
                         OP_RET = 3'd3, OP_INT = 3'd4, OP_RTI = 3'd5, OP_NOP = 3'd7;

  logic              clk = 1'b0;
  logic              rst, req, sp_init;
  logic [2:0]        op;
  logic [15:0]       push_data, flags_in;
  logic [31:0]       pc_in, sp;
  logic              sp_en, sp_pop, mem_we, mem_re, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata, mem_rdata, pop_data, flags_out;
  logic [31:0]       pc_out;
  logic [15:0]       mem [0:2047];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n;
  logic mon_en = 1'b0;

  typedef struct { int cyc; logic we; logic [10:0] addr; logic [15:0] wdata; } acc_t;
  typedef struct { int cyc; logic [15:0] pop; logic [31:0] pc; logic [15:0] fl; logic err; } cmp_t;
  acc_t acc_q[$];
  cmp_t cmp_q[$];
  acc_t ma;
  cmp_t mc;

  stack_access_ctrl #(.ADDR_W(ADDR_W), .STACK_TOP(2047), .STACK_LIMIT(1024)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .push_data(push_data), .pc_in(pc_in),
    .flags_in(flags_in), .sp(sp), .sp_en(sp_en), .sp_pop(sp_pop), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pop_data(pop_data), .pc_out(pc_out), .flags_out(flags_out),
    .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stack pointer register and synchronous-read data memory.
  always @(posedge clk) begin
    if (sp_init) begin
      sp <= 32'd2047;
      mem_rdata <= 16'h0;
      for (int i = 0; i < 2048; i++) mem[i] <= 16'h0;
      mem[0] <= 16'h5A5A;
    end else begin
      if (sp_en) sp <= sp_pop ? sp + 32'd1 : sp - 32'd1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sp_en || mem_we || mem_re) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_access actual=we%0b re%0b addr%0d required=none",
                   mem_we, mem_re, mem_addr);
        end else begin
          ma = acc_q.pop_front();
          chk("acc_cycle", 32'(cyc), 32'(ma.cyc));
          chk("acc_we", 32'(mem_we), 32'(ma.we));
          chk("acc_re", 32'(mem_re), 32'(!ma.we));
          chk("acc_addr", 32'(mem_addr), 32'(ma.addr));
          if (ma.we) chk("acc_wdata", 32'(mem_wdata), 32'(ma.wdata));
          chk("acc_sp_en", 32'(sp_en), 32'd1);
          chk("acc_sp_pop", 32'(sp_pop), 32'(!ma.we));
        end
      end
      if (done) begin
        if (cmp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          mc = cmp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(mc.cyc));
          chk("pop_data", 32'(pop_data), 32'(mc.pop));
          chk("pc_out", pc_out, mc.pc);
          chk("flags_out", 32'(flags_out), 32'(mc.fl));
          chk("err", 32'(err), 32'(mc.err));
        end
      end
    end
  end

  task automatic exp_w(input int c, input logic [10:0] a, input logic [15:0] d);
    acc_q.push_back('{cyc: c, we: 1'b1, addr: a, wdata: d});
  endtask

  task automatic exp_r(input int c, input logic [10:0] a);
    acc_q.push_back('{cyc: c, we: 1'b0, addr: a, wdata: 16'h0});
  endtask

  task automatic exp_done(input int c, input logic [15:0] p, input logic [31:0] pc,
                          input logic [15:0] f, input logic e);
    cmp_q.push_back('{cyc: c, pop: p, pc: pc, fl: f, err: e});
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL timeout_idle actual=busy required=idle");
    end
  endtask

  // Drives req in the current cycle; acceptance cycle returned in n before any access can occur.
  task automatic start(input logic [2:0] o, input logic [15:0] pd, input logic [31:0] pc,
                       input logic [15:0] fl);
    wait_idle();
    req = 1'b1;
    op = o;
    push_data = pd;
    pc_in = pc;
    flags_in = fl;
    n = cyc;
  endtask

  task automatic release_req();
    @(negedge clk);
    req = 1'b0;
    op = ~op;
    push_data = ~push_data;
    pc_in = ~pc_in;
    flags_in = ~flags_in;
  endtask

  initial begin
    rst = 1'b1;
    sp_init = 1'b1;
    req = 1'b0;
    op = 3'd0;
    push_data = 16'h0;
    pc_in = 32'h0;
    flags_in = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sp_en", 32'(sp_en), 32'd0);
    chk("rst_sp_pop", 32'(sp_pop), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_pop_data", 32'(pop_data), 32'd0);
    chk("rst_pc_out", pc_out, 32'd0);
    chk("rst_flags_out", 32'(flags_out), 32'd0);
    rst = 1'b0;
    sp_init = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    start(OP_PUSH, 16'hBEEF, 32'h0, 16'h0);
    exp_w(n + 1, 11'd2047, 16'hBEEF);
    exp_done(n + 2, 16'h0, 32'h0, 16'h0, 1'b0);
    release_req();
    chk("busy_push_n1", 32'(busy), 32'd1);

    start(OP_POP, 16'h0, 32'h0, 16'h0);
    exp_r(n + 1, 11'd2047);
    exp_done(n + 3, 16'hBEEF, 32'h0, 16'h0, 1'b0);
    release_req();

    start(OP_CALL, 16'h0, 32'h0001_2345, 16'h0);
    exp_w(n + 1, 11'd2047, 16'h0001);
    exp_w(n + 2, 11'd2046, 16'h2345);
    exp_done(n + 3, 16'hBEEF, 32'h0, 16'h0, 1'b0);
    release_req();
    wait_idle();
    chk("sp_after_call", sp, 32'd2045);

    start(OP_RET, 16'h0, 32'h0, 16'h0);
    exp_r(n + 1, 11'd2046);
    exp_r(n + 2, 11'd2047);
    exp_done(n + 4, 16'hBEEF, 32'h0001_2345, 16'h0, 1'b0);
    release_req();
    wait_idle();
    chk("sp_after_ret", sp, 32'd2047);

    start(OP_INT, 16'h0, 32'h0000_00A0, 16'h0005);
    exp_w(n + 1, 11'd2047, 16'h0000);
    exp_w(n + 2, 11'd2046, 16'h00A0);
    exp_w(n + 3, 11'd2045, 16'h0005);
    exp_done(n + 4, 16'hBEEF, 32'h0001_2345, 16'h0, 1'b0);
    release_req();

    start(OP_RTI, 16'h0, 32'h0, 16'h0);
    exp_r(n + 1, 11'd2045);
    exp_r(n + 2, 11'd2046);
    exp_r(n + 3, 11'd2047);
    exp_done(n + 5, 16'hBEEF, 32'h0000_00A0, 16'h0005, 1'b0);
    release_req();
    wait_idle();
    chk("sp_after_rti", sp, 32'd2047);

    start(OP_NOP, 16'h1234, 32'h5555_AAAA, 16'h7777);
    exp_done(n + 1, 16'hBEEF, 32'h0000_00A0, 16'h0005, 1'b0);
    release_req();

    start(OP_PUSH, 16'h1111, 32'h0, 16'h0);
    exp_w(n + 1, 11'd2047, 16'h1111);
    exp_done(n + 2, 16'hBEEF, 32'h0000_00A0, 16'h0005, 1'b0);
    release_req();
    start(OP_PUSH, 16'h2222, 32'h0, 16'h0);
    exp_w(n + 1, 11'd2046, 16'h2222);
    exp_done(n + 2, 16'hBEEF, 32'h0000_00A0, 16'h0005, 1'b0);
    release_req();
    start(OP_POP, 16'h0, 32'h0, 16'h0);
    exp_r(n + 1, 11'd2046);
    exp_done(n + 3, 16'h2222, 32'h0000_00A0, 16'h0005, 1'b0);
    release_req();
    start(OP_POP, 16'h0, 32'h0, 16'h0);
    exp_r(n + 1, 11'd2047);
    exp_done(n + 3, 16'h1111, 32'h0000_00A0, 16'h0005, 1'b0);
    release_req();

    // Reset lands on the second write of a CALL.
    start(OP_CALL, 16'h0, 32'hCAFE_F00D, 16'h0);
    exp_w(n + 1, 11'd2047, 16'hCAFE);
    exp_w(n + 2, 11'd2046, 16'hF00D);
    release_req();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_mem_we", 32'(mem_we), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_first_word", 32'(mem[2047]), 32'h0000_CAFE);
    chk("midrst_pc_out", pc_out, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    start(OP_POP, 16'h0, 32'h0, 16'h0);
    exp_r(n + 1, 11'd2046);
    exp_done(n + 3, 16'hF00D, 32'h0, 16'h0, 1'b0);
    release_req();
    start(OP_POP, 16'h0, 32'h0, 16'h0);
    exp_r(n + 1, 11'd2047);
    exp_done(n + 3, 16'hCAFE, 32'h0, 16'h0, 1'b0);
    release_req();
    wait_idle();
    chk("sp_before_edge_pop", sp, 32'd2047);

    start(OP_POP, 16'h0, 32'h0, 16'h0);
`ifdef STACK_BOUNDS_EN
    exp_done(n + 1, 16'hCAFE, 32'h0, 16'h0, 1'b1);
`else
    exp_r(n + 1, 11'd0);
    exp_done(n + 3, 16'h5A5A, 32'h0, 16'h0, 1'b0);
`endif
    release_req();
    wait_idle();
`ifdef STACK_BOUNDS_EN
    chk("sp_after_underflow", sp, 32'd2047);
`else
    chk("sp_after_wrap_pop", sp, 32'd2048);
`endif

    repeat (3) @(negedge clk);
    chk("acc_queue_empty", 32'(acc_q.size()), 32'd0);
    chk("done_queue_empty", 32'(cmp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
